// File: rtl/tis_port_sink.sv
// Sink for a node write port: a three-state handshake FSM accepts one value per
// wvalid assertion into a show-ahead FIFO, which a host drains with rd_en.
module tis_port_sink #(
    parameter int W     = 11,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wvalid,
    input  logic [W-1:0]               wdata,
    output logic                       wready,
    input  logic                       rd_en,
    output logic [W-1:0]               rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                accepted,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        DROP = 2'd2
    } wr_state_e;

    wr_state_e       state_q;
    logic            run_q;
    logic            wready_q;
    logic [AW-1:0]   head_q;
    logic [AW-1:0]   tail_q;
    logic [CW-1:0]   count_q;
    logic [15:0]     accepted_q;
    logic            underflow_q;
    logic [W-1:0]    mem [DEPTH];

    logic push;
    logic pop;

    // Flags come from the registered count only, so full never sees a same-edge pop.
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    assign push = (state_q == IDLE) && run_q && wvalid && !full;
    assign pop  = rd_en && !empty;

    assign wready    = wready_q;
    assign rd_data   = mem[head_q];
    assign count     = count_q;
    assign accepted  = accepted_q;
    assign underflow = underflow_q;

    // Reset release is registered once so the FSM's first capture is the second edge after release.
    // NOTE: sequential state is always written with non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (push) begin
                        wready_q <= 1'b1;
                        state_q  <= ACK;
                    end else begin
                        wready_q <= 1'b0;
                    end
                end
                ACK: begin
                    wready_q <= 1'b0;
                    state_q  <= DROP;
                end
                DROP: begin
                    wready_q <= 1'b0;
                    if (!wvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    wready_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            accepted_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            if (push) begin
                tail_q     <= tail_q + 1'b1;
                accepted_q <= accepted_q + 16'd1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (rd_en && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // NOTE: storage has no reset; rd_data is only meaningful when empty=0, and leaving
    // the array out of reset lets it map onto plain RAM/register-file cells.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_q] <= wdata;
        end
    end

endmodule

// File: tb/tb_tis_port_sink.sv
// Directed bench for tis_port_sink: handshake, FIFO ordering, stall on full,
// underflow and asynchronous reset behaviour, each checked against hand values.
module tb_tis_port_sink;

    localparam int W     = 11;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          wvalid;
    logic [W-1:0]  wdata;
    logic          wready;
    logic          rd_en;
    logic [W-1:0]  rd_data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic [15:0]   accepted;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    tis_port_sink #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wvalid    (wvalid),
        .wdata     (wdata),
        .wready    (wready),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .accepted  (accepted),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        wvalid = 1'b0;
        rd_en  = 1'b0;
        wdata  = '0;
        rst_n  = 1'b0;
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    // Full handshake for one value; returns with the FSM back in IDLE.
    task automatic write_word(input logic [W-1:0] val);
        bit got;
        got    = 1'b0;
        wvalid = 1'b1;
        wdata  = val;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (wready === 1'b1) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL write_ack_timeout value %0d got no wready within 20 cycles", val);
        end
        wvalid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        wvalid = 1'b0;
        rd_en  = 1'b0;
        wdata  = '0;
        rst_n  = 1'b0;
        #1;
        checks++;
        if ({wready, count, empty, full, accepted, underflow} !==
            {1'b0, 4'd0, 1'b1, 1'b0, 16'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state wready=%b count=%0d empty=%b full=%b accepted=%0d underflow=%b exp 0 0 1 0 0 0",
                     wready, count, empty, full, accepted, underflow);
        end
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_single_write();
        int pulses;
        wvalid = 1'b1;
        wdata  = 11'h7FF;
        tick();
        checks++;
        if (wready !== 1'b1) begin
            errors++;
            $display("FAIL single_wready got %b exp 1", wready);
        end
        checks++;
        if (count !== 4'd1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL single_count got count=%0d empty=%b exp 1 0", count, empty);
        end
        checks++;
        if (rd_data !== 11'h7FF) begin
            errors++;
            $display("FAIL single_rd_data got %h exp 7ff", rd_data);
        end
        checks++;
        if (accepted !== 16'd1) begin
            errors++;
            $display("FAIL single_accepted got %0d exp 1", accepted);
        end
        wvalid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wready === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL single_pulse_width got %0d extra wready cycles exp 0", pulses);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (empty !== 1'b1 || count !== 4'd0) begin
            errors++;
            $display("FAIL single_pop got empty=%b count=%0d exp 1 0", empty, count);
        end
    endtask

    task automatic test_held_wvalid();
        int pulses;
        pulses = 0;
        wvalid = 1'b1;
        wdata  = 11'd42;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (wready === 1'b1) pulses++;
        end
        wvalid = 1'b0;
        tick();
        tick();
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL held_pulses got %0d exp 1", pulses);
        end
        checks++;
        if (count !== 4'd1 || rd_data !== 11'd42) begin
            errors++;
            $display("FAIL held_entry got count=%0d rd_data=%0d exp 1 42", count, rd_data);
        end
        checks++;
        if (accepted !== 16'd2) begin
            errors++;
            $display("FAIL held_accepted got %0d exp 2", accepted);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_fill_stall();
        int stray;
        for (int v = 1; v <= 8; v++) write_word(W'(v));
        checks++;
        if (full !== 1'b1 || count !== 4'd8) begin
            errors++;
            $display("FAIL fill_full got full=%b count=%0d exp 1 8", full, count);
        end
        stray  = 0;
        wvalid = 1'b1;
        wdata  = 11'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wready === 1'b1) stray++;
        end
        checks++;
        if (stray != 0 || count !== 4'd8) begin
            errors++;
            $display("FAIL fill_stall got wready_cycles=%0d count=%0d exp 0 8", stray, count);
        end
        // Pop while full: no same-edge push may ride on the freed slot.
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (wready !== 1'b0 || count !== 4'd7 || rd_data !== 11'd2) begin
            errors++;
            $display("FAIL fill_no_bypass got wready=%b count=%0d rd_data=%0d exp 0 7 2", wready, count, rd_data);
        end
        tick();
        checks++;
        if (wready !== 1'b1 || count !== 4'd8) begin
            errors++;
            $display("FAIL fill_resume got wready=%b count=%0d exp 1 8", wready, count);
        end
        wvalid = 1'b0;
        tick();
        tick();
        for (int v = 2; v <= 9; v++) begin
            checks++;
            if (rd_data !== W'(v) || empty !== 1'b0) begin
                errors++;
                $display("FAIL fill_order got rd_data=%0d empty=%b exp %0d 0", rd_data, empty, v);
            end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        checks++;
        if (empty !== 1'b1 || accepted !== 16'd11) begin
            errors++;
            $display("FAIL fill_drained got empty=%b accepted=%0d exp 1 11", empty, accepted);
        end
    endtask

    task automatic test_push_pop();
        for (int v = 10; v <= 12; v++) write_word(W'(v));
        wvalid = 1'b1;
        wdata  = 11'd13;
        rd_en  = 1'b1;
        tick();
        rd_en  = 1'b0;
        wvalid = 1'b0;
        checks++;
        if (count !== 4'd3 || wready !== 1'b1 || rd_data !== 11'd11) begin
            errors++;
            $display("FAIL pushpop got count=%0d wready=%b rd_data=%0d exp 3 1 11", count, wready, rd_data);
        end
        tick();
        tick();
        for (int v = 11; v <= 13; v++) begin
            checks++;
            if (rd_data !== W'(v)) begin
                errors++;
                $display("FAIL pushpop_order got %0d exp %0d", rd_data, v);
            end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
    endtask

    // Keep up to four values in flight so head and tail both wrap several times.
    task automatic test_wrap();
        int next_exp;
        next_exp = 0;
        for (int v = 0; v < 20; v++) begin
            write_word(W'(v));
            if (count == 4'd4) begin
                checks++;
                if (rd_data !== W'(next_exp)) begin
                    errors++;
                    $display("FAIL wrap_order got %0d exp %0d", rd_data, next_exp);
                end
                next_exp++;
                rd_en = 1'b1;
                tick();
                rd_en = 1'b0;
            end
        end
        while (next_exp < 20 && empty === 1'b0) begin
            checks++;
            if (rd_data !== W'(next_exp)) begin
                errors++;
                $display("FAIL wrap_order got %0d exp %0d", rd_data, next_exp);
            end
            next_exp++;
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        checks++;
        if (next_exp != 20 || empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_total got popped=%0d empty=%b exp 20 1", next_exp, empty);
        end
    endtask

    task automatic test_underflow();
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_pre got %b exp 0", underflow);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
        if (underflow !== 1'b1 || count !== 4'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL underflow_set got underflow=%b count=%0d empty=%b exp 1 0 1", underflow, count, empty);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_sticky got %b exp 1", underflow);
        end
    endtask

    task automatic test_reset_mid_handshake();
        int extra;
        apply_reset();
        for (int v = 1; v <= 3; v++) write_word(W'(v * 100));
        wvalid = 1'b1;
        wdata  = 11'd77;
        tick();
        checks++;
        if (wready !== 1'b1 || count !== 4'd4) begin
            errors++;
            $display("FAIL midrst_setup got wready=%b count=%0d exp 1 4", wready, count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (wready !== 1'b0 || count !== 4'd0 || accepted !== 16'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL midrst_async got wready=%b count=%0d accepted=%0d empty=%b exp 0 0 0 1",
                     wready, count, accepted, empty);
        end
        #2;
        rst_n = 1'b1;
        tick();
        checks++;
        if (wready !== 1'b0 || count !== 4'd0) begin
            errors++;
            $display("FAIL midrst_edge1 got wready=%b count=%0d exp 0 0", wready, count);
        end
        tick();
        checks++;
        if (wready !== 1'b1 || count !== 4'd1 || rd_data !== 11'd77 || accepted !== 16'd1) begin
            errors++;
            $display("FAIL midrst_edge2 got wready=%b count=%0d rd_data=%0d accepted=%0d exp 1 1 77 1",
                     wready, count, rd_data, accepted);
        end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wready === 1'b1) extra++;
        end
        wvalid = 1'b0;
        checks++;
        if (extra != 0 || count !== 4'd1) begin
            errors++;
            $display("FAIL midrst_single got extra_wready=%0d count=%0d exp 0 1", extra, count);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_held_wvalid();
        test_fill_stall();
        test_push_pop();
        test_wrap();
        test_underflow();
        test_reset_mid_handshake();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tis_port_sink.md
TIS_PORT_SINK -- requirements
Module: tis_port_sink

Interface
REQ-001 Parameter: W, 11, data width; matches the signed node accumulator width.
REQ-002 Parameter: DEPTH, 8, FIFO entries; power of two, minimum 2.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: wvalid  input  1  node write request; held high until acknowledged.
REQ-006 Port: wdata  input  W  signed value offered by the writing node; stable while wvalid=1.
REQ-007 Port: wready  output  1  registered one-cycle acknowledge to the writing node; drives a node's wreadyD.
REQ-008 Port: rd_en  input  1  host pop request.
REQ-009 Port: rd_data  output  W  FIFO head value, show-ahead; valid when empty=0.
REQ-010 Port: empty  output  1  FIFO holds zero entries.
REQ-011 Port: full  output  1  FIFO holds DEPTH entries.
REQ-012 Port: count  output  $clog2(DEPTH)+1  current number of entries.
REQ-013 Port: accepted  output  16  total values accepted since reset.
REQ-014 Port: underflow  output  1  sticky flag: rd_en seen while empty.

Function
REQ-015 Write-side FSM SHALL have three states: IDLE, ACK and DROP.
REQ-016 IDLE: if wvalid=1 and full=0 at the edge -> write wdata at the tail, set wready<=1, go to ACK; otherwise stay in IDLE with wready=0.
REQ-017 ACK: wready SHALL be 1 for exactly this one cycle; next edge -> wready<=0, go to DROP.
REQ-018 DROP: stay while wvalid=1, with no further capture; go to IDLE on the first edge where wvalid=0.
REQ-019 One wvalid assertion SHALL produce exactly one FIFO write and exactly one wready pulse.
REQ-020 Write latency: the value is present in the FIFO and wready=1 in the cycle after the accepting edge.
REQ-021 With full=1 in IDLE: no capture and no wready; the writer stalls until a pop frees an entry.
REQ-022 Pop: rd_en=1 and empty=0 at the edge -> advance head; rd_data shows the next entry in the following cycle.
REQ-023 Push and pop in the same edge SHALL both occur, with count unchanged.
REQ-024 full SHALL be evaluated on pre-edge count, with no bypass: when full, a same-edge pop does not enable a push.
REQ-025 Push into an empty FIFO: rd_data=new value and empty=0 in the next cycle.
REQ-026 rd_en while empty: no state change; underflow<=1, held until reset.
REQ-027 Head and tail pointers SHALL wrap modulo DEPTH; FIFO order is strictly first-in, first-out across wrap.
REQ-028 accepted SHALL increment by 1 per FIFO write and wrap from 16'hFFFF to 0.
REQ-029 Data SHALL be stored bit-exact, signed, W bits, with no saturation or extension.
REQ-030 empty, full and count SHALL be derived from registered state only, with no combinational path from the wvalid/rd_en inputs.

Reset
REQ-031 rst_n=0 SHALL immediately force: FSM=IDLE, wready=0, count=0, empty=1, full=0, accepted=0, underflow=0, pointers=0.
REQ-032 rd_data is don't-care while empty=1; FIFO storage needs no reset.
REQ-033 Reset in ACK or DROP SHALL abort the handshake; after release, a still-high wvalid is treated as a new write in IDLE.
REQ-034 Deassertion of rst_n SHALL be synchronised to clk before FSM use; the first possible capture is the second edge after release.

Verification
REQ-035 Single write: wvalid=1, wdata=11'h7FF (-1) -> wready pulse 1 cycle; count=1; rd_data=11'h7FF; accepted=1.
REQ-036 Held wvalid: wvalid high 5 cycles with wdata=11'd42 -> exactly one wready pulse, count=1, no duplicate entry.
REQ-037 Fill and stall: 9 writes (values 1..9), DEPTH=8, no pops -> full=1 after 8; write 9 gets no wready; one pop of 1 -> value 9 accepted; popped order 2..9.
REQ-038 Simultaneous push/pop at count=3 -> count stays 3; wrap test with 20 sequential writes/pops yields values 0..19 in order.
REQ-039 Underflow: rd_en=1 on empty -> underflow=1, count=0, and underflow is still 1 after 10 more idle cycles.
REQ-040 Reset mid-handshake: rst_n=0 during ACK with count=4 -> wready=0, count=0 and accepted=0 immediately (asynchronously); with wvalid held high, exactly one new capture after release.
